// File: rtl/sram_sync.sv
// Single-port synchronous RAM with a registered, one-cycle-latency read port.
// Define SRAM_INIT_ZERO_EN to make rst also clear the storage array.
module sram_sync #(
   parameter int unsigned SIZE       = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  re,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out
);

   logic [DATA_WIDTH-1:0] mem [SIZE];
   logic [DATA_WIDTH-1:0] data_q;
   logic                  in_range;

   assign in_range = (32'(addr) < SIZE);
   assign data_out = data_q;

   // Read-before-write falls out of non-blocking semantics on a shared address.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
      end else if (re) begin
         data_q <= in_range ? mem[addr] : '0;
      end
   end

`ifdef SRAM_INIT_ZERO_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(SIZE); i++) begin
            mem[i] <= '0;
         end
      end else if (we && in_range) begin
         mem[addr] <= data_in;
      end
   end
`else
   // No reset on the array so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (!rst && we && in_range) begin
         mem[addr] <= data_in;
      end
   end
`endif

endmodule

// File: tb/tb_sram_sync.sv
// Directed self-checking bench for sram_sync: a full-size instance and a
// SIZE=12 instance share one stimulus bus so out-of-range handling can be checked.
module tb_sram_sync;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  addr = '0;
   logic        re = 1'b0;
   logic        we = 1'b0;
   logic [31:0] data_in = '0;
   logic [31:0] dout_full;
   logic [31:0] dout_small;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sram_sync #(
      .SIZE       (16),
      .DATA_WIDTH (32),
      .ADDR_WIDTH (4)
   ) u_full (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .re       (re),
      .we       (we),
      .data_in  (data_in),
      .data_out (dout_full)
   );

   sram_sync #(
      .SIZE       (12),
      .DATA_WIDTH (32),
      .ADDR_WIDTH (4)
   ) u_small (
      .clk      (clk),
      .rst      (rst),
      .addr     (addr),
      .re       (re),
      .we       (we),
      .data_in  (data_in),
      .data_out (dout_small)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
      end
   endtask

   // Drive one request, let the edge sample it, then return 1 time unit after the edge.
   task automatic op(input logic r, input logic rd, input logic wr,
                     input logic [3:0] a, input logic [31:0] d);
      rst     = r;
      re      = rd;
      we      = wr;
      addr    = a;
      data_in = d;
      @(posedge clk);
      #1;
      rst = 1'b0;
      re  = 1'b0;
      we  = 1'b0;
   endtask

   logic [31:0] exp_rst;

   initial begin
      #1;
      // Reset with re/we asserted must clear data_out and write nothing.
      op(1'b0, 1'b0, 1'b1, 4'd3, 32'h0BAD_F00D);
      op(1'b1, 1'b1, 1'b1, 4'd3, 32'h5555_5555);
      check("reset_cycle1", dout_full, 32'h0);
      op(1'b1, 1'b1, 1'b1, 4'd3, 32'h5555_5555);
      check("reset_cycle2", dout_full, 32'h0);
`ifdef SRAM_INIT_ZERO_EN
      exp_rst = 32'h0;
`else
      exp_rst = 32'h0BAD_F00D;
`endif
      op(1'b0, 1'b1, 1'b0, 4'd3, 32'h0);
      check("reset_no_write", dout_full, exp_rst);

      // Write-only sweep must not disturb data_out.
      for (int i = 0; i < 16; i++) begin
         op(1'b0, 1'b0, 1'b1, 4'(i), 32'hDEAD_BEEF);
         check($sformatf("sweep_wr_hold_%0d", i), dout_full, exp_rst);
      end
      for (int i = 0; i < 16; i++) begin
         op(1'b0, 1'b1, 1'b0, 4'(i), 32'h0);
         check($sformatf("sweep_rd_%0d", i), dout_full, 32'hDEAD_BEEF);
      end

      // Distinct data, back-to-back reads in reverse order, then hold.
      for (int i = 0; i < 16; i++) begin
         op(1'b0, 1'b0, 1'b1, 4'(i), 32'h1000_0000 + 32'(i));
      end
      for (int i = 15; i >= 0; i--) begin
         op(1'b0, 1'b1, 1'b0, 4'(i), 32'h0);
         check($sformatf("distinct_rd_%0d", i), dout_full, 32'h1000_0000 + 32'(i));
      end
      op(1'b0, 1'b0, 1'b0, 4'd9, 32'h0);
      check("hold_1", dout_full, 32'h1000_0000);
      op(1'b0, 1'b0, 1'b0, 4'd7, 32'h0);
      check("hold_2", dout_full, 32'h1000_0000);

      // Same-address read and write returns the old word.
      op(1'b0, 1'b0, 1'b1, 4'd5, 32'hAAAA_5555);
      op(1'b0, 1'b1, 1'b1, 4'd5, 32'h1234_5678);
      check("rdw_old", dout_full, 32'hAAAA_5555);
      op(1'b0, 1'b1, 1'b0, 4'd5, 32'h0);
      check("rdw_new", dout_full, 32'h1234_5678);

      // Out-of-range handling on the SIZE=12 instance.
      for (int i = 0; i < 12; i++) begin
         op(1'b0, 1'b0, 1'b1, 4'(i), 32'h2000_0000 + 32'(i));
      end
      op(1'b0, 1'b1, 1'b0, 4'd1, 32'h0);
      check("oor_pre_rd1", dout_small, 32'h2000_0001);
      op(1'b0, 1'b0, 1'b1, 4'd13, 32'hFFFF_FFFF);
      op(1'b0, 1'b1, 1'b0, 4'd13, 32'h0);
      check("oor_rd13_small", dout_small, 32'h0);
      check("oor_rd13_full", dout_full, 32'hFFFF_FFFF);
      op(1'b0, 1'b0, 1'b1, 4'd12, 32'hFFFF_FFFF);
      op(1'b0, 1'b0, 1'b1, 4'd14, 32'hFFFF_FFFF);
      op(1'b0, 1'b0, 1'b1, 4'd15, 32'hFFFF_FFFF);
      for (int i = 0; i < 12; i++) begin
         op(1'b0, 1'b1, 1'b0, 4'(i), 32'h0);
         check($sformatf("oor_no_alias_%0d", i), dout_small, 32'h2000_0000 + 32'(i));
      end

      // Fill, single-cycle reset, read back everything.
      for (int i = 0; i < 16; i++) begin
         op(1'b0, 1'b0, 1'b1, 4'(i), 32'hDEAD_BEEF);
      end
      op(1'b1, 1'b0, 1'b0, 4'd0, 32'h0);
      check("init_rst_out", dout_full, 32'h0);
`ifdef SRAM_INIT_ZERO_EN
      exp_rst = 32'h0;
`else
      exp_rst = 32'hDEAD_BEEF;
`endif
      for (int i = 0; i < 16; i++) begin
         op(1'b0, 1'b1, 1'b0, 4'(i), 32'h0);
         check($sformatf("init_rd_%0d", i), dout_full, exp_rst);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
